// File: rtl/pc_fetch_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer and its helpers.
package pc_fetch_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_e;

    typedef logic [31:0] word_addr_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    // Wide enough for any timeout in 1..255.
    localparam int unsigned CTR_W = 8;

    function automatic logic is_word_aligned(input word_addr_t addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
module fetch_timeout_ctr #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TERM_COUNT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Clear dominates load, load dominates increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == WIDTH'(TERM_COUNT));

endmodule

// File: rtl/pc_fetch_seq.sv
// Front-end sequencer: owns the PC, fetches over req/ack, issues to the core, retires on done.
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [31:0]      pc_o,
    input  logic [31:0]      npc_i,
    input  logic             core_done_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [CNT_W-1:0] retired_o,
    output logic             halted_o,
    output logic [1:0]       err_code_o
);

    state_e           state_q, state_d;
    word_addr_t       pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       err_q, err_d;

    logic             ctr_clr, ctr_inc, ctr_tc;
    logic [CTR_W-1:0] ctr_cnt;

    fetch_timeout_ctr #(
        .WIDTH      (CTR_W),
        .TERM_COUNT (TIMEOUT - 1)
    ) u_timeout_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (ctr_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (ctr_inc),
        .cnt_o      (ctr_cnt),
        .tc_o       (ctr_tc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        err_d     = err_q;
        ctr_clr   = 1'b0;
        ctr_inc   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack on the terminal cycle still wins over the timeout.
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    ctr_clr = 1'b1;
                    state_d = S_ISSUE;
                end else if (ctr_tc) begin
                    err_d   = ERR_TIMEOUT;
                    ctr_clr = 1'b1;
                    state_d = S_HALT;
                end else begin
                    ctr_inc = 1'b1;
                end
            end
            S_ISSUE: begin
                if (core_done_i) begin
                    if (is_word_aligned(npc_i)) begin
                        pc_d      = npc_i;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            err_q     <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    // Control outputs decode from the state register only, so none depend on inputs.
    assign imem_req_o    = (state_q == S_FETCH);
    assign instr_valid_o = (state_q == S_ISSUE);
    assign halted_o      = (state_q == S_HALT);
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign retired_o     = retired_q;
    assign err_code_o    = err_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: reset abort, fetch/issue flow, stalls, errors, throughput.
module tb_pc_fetch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // Main instance: reset PC 0, short timeout.
    logic        a_rst, a_core_done, a_ack;
    logic [31:0] a_npc, a_rdata, a_pc, a_instr, a_addr, a_retired;
    logic        a_valid, a_req, a_halted;
    logic [1:0]  a_err;

    // Second instance only for the reset-abort scenario.
    logic        b_rst;
    logic [31:0] b_pc, b_instr, b_addr, b_retired;
    logic        b_valid, b_req, b_halted;
    logic [1:0]  b_err;

    pc_fetch_seq #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (4),
        .CNT_W    (32)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (a_rst),
        .pc_o          (a_pc),
        .npc_i         (a_npc),
        .core_done_i   (a_core_done),
        .instr_o       (a_instr),
        .instr_valid_o (a_valid),
        .imem_req_o    (a_req),
        .imem_addr_o   (a_addr),
        .imem_ack_i    (a_ack),
        .imem_rdata_i  (a_rdata),
        .retired_o     (a_retired),
        .halted_o      (a_halted),
        .err_code_o    (a_err)
    );

    pc_fetch_seq #(
        .RESET_PC (32'h0000_0100),
        .TIMEOUT  (16),
        .CNT_W    (32)
    ) u_dut_rst (
        .clk_i         (clk),
        .rst_i         (b_rst),
        .pc_o          (b_pc),
        .npc_i         (32'h0),
        .core_done_i   (1'b0),
        .instr_o       (b_instr),
        .instr_valid_o (b_valid),
        .imem_req_o    (b_req),
        .imem_addr_o   (b_addr),
        .imem_ack_i    (1'b0),
        .imem_rdata_i  (32'h0),
        .retired_o     (b_retired),
        .halted_o      (b_halted),
        .err_code_o    (b_err)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        int unsigned t0;

        a_rst = 1'b1; b_rst = 1'b1;
        a_core_done = 1'b0; a_ack = 1'b0; a_npc = '0; a_rdata = '0;
        step(); step();

        // 1. Reset pulse mid-fetch on the RESET_PC=0x100 instance.
        b_rst = 1'b0;
        chk("t1_idle_no_req", {31'b0, b_req}, 32'h0);
        step();
        chk("t1_fetch_req", {31'b0, b_req}, 32'h1);
        chk("t1_fetch_addr", b_addr, 32'h100);
        step();
        #2 b_rst = 1'b1;
        #1;
        chk("t1_req_async_drop", {31'b0, b_req}, 32'h0);
        chk("t1_pc_reset", b_pc, 32'h100);
        step();
        b_rst = 1'b0;
        chk("t1_post_idle", {31'b0, b_req}, 32'h0);
        chk("t1_post_pc", b_pc, 32'h100);
        step();
        chk("t1_refetch_req", {31'b0, b_req}, 32'h1);
        chk("t1_refetch_addr", b_addr, 32'h100);
        chk("t1_no_halt", {31'b0, b_halted}, 32'h0);

        // Reset state of the main instance.
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_instr", a_instr, 32'h0);
        chk("rst_valid", {31'b0, a_valid}, 32'h0);
        chk("rst_req", {31'b0, a_req}, 32'h0);
        chk("rst_retired", a_retired, 32'h0);
        chk("rst_halted", {31'b0, a_halted}, 32'h0);
        chk("rst_err", {30'b0, a_err}, 32'h0);

        // 2. One-cycle memory, then core_done with nPC=4.
        a_rst = 1'b0;
        chk("t2_idle_no_req", {31'b0, a_req}, 32'h0);
        step();
        chk("t2_req", {31'b0, a_req}, 32'h1);
        chk("t2_addr", a_addr, 32'h0);
        a_ack = 1'b1; a_rdata = 32'h2002_000A;
        step();
        a_ack = 1'b0;
        chk("t2_instr", a_instr, 32'h2002_000A);
        chk("t2_valid", {31'b0, a_valid}, 32'h1);
        chk("t2_no_req_issue", {31'b0, a_req}, 32'h0);
        a_core_done = 1'b1; a_npc = 32'h4;
        step();
        a_core_done = 1'b0;
        chk("t2_next_addr", a_addr, 32'h4);
        chk("t2_retired", a_retired, 32'h1);
        chk("t2_refetch_req", {31'b0, a_req}, 32'h1);
        chk("t2_valid_drop", {31'b0, a_valid}, 32'h0);

        // 3. Three wait cycles, ack on the terminal (4th) cycle, then a 5-cycle issue hold.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_wait_req", {31'b0, a_req}, 32'h1);
            chk("t3_wait_pc", a_pc, 32'h4);
            chk("t3_wait_halted", {31'b0, a_halted}, 32'h0);
        end
        a_ack = 1'b1; a_rdata = 32'h1234_5678;
        step();
        a_rdata = 32'hFFFF_0000; // ack stays high; must be ignored while issuing
        chk("t3_issue_valid", {31'b0, a_valid}, 32'h1);
        chk("t3_issue_instr", a_instr, 32'h1234_5678);
        chk("t3_ack_wins_err", {30'b0, a_err}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_valid", {31'b0, a_valid}, 32'h1);
            chk("t3_hold_no_req", {31'b0, a_req}, 32'h0);
            chk("t3_hold_pc", a_pc, 32'h4);
            chk("t3_hold_instr", a_instr, 32'h1234_5678);
        end
        a_ack = 1'b0;
        a_core_done = 1'b1; a_npc = 32'h0;
        step();
        a_core_done = 1'b0;
        chk("t3_pc_back", a_pc, 32'h0);
        chk("t3_retired", a_retired, 32'h2);

        // 6. Ten back-to-back instructions with nPC=PC+4.
        exp_pc = 32'h0;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            a_ack = 1'b1; a_rdata = 32'hA000_0000 + i;
            step();
            a_ack = 1'b0;
            chk("t6_instr", a_instr, 32'hA000_0000 + i);
            a_core_done = 1'b1; a_npc = exp_pc + 32'h4;
            step();
            a_core_done = 1'b0;
            exp_pc = exp_pc + 32'h4;
            chk("t6_pc", a_pc, exp_pc);
        end
        chk("t6_retired", a_retired, 32'd12);
        chk("t6_final_pc", a_pc, 32'h28);
        chk("t6_cycles", cyc - t0, 32'd20);

        // 4. Misaligned nPC halts sticky.
        a_ack = 1'b1; a_rdata = 32'hDEAD_BEEF;
        step();
        a_ack = 1'b0;
        a_core_done = 1'b1; a_npc = 32'h6;
        step();
        a_core_done = 1'b0;
        chk("t4_halted", {31'b0, a_halted}, 32'h1);
        chk("t4_err", {30'b0, a_err}, 32'h1);
        chk("t4_pc", a_pc, 32'h28);
        chk("t4_retired", a_retired, 32'd12);
        chk("t4_no_req", {31'b0, a_req}, 32'h0);
        a_ack = 1'b1; a_core_done = 1'b1; a_npc = 32'h8;
        step(); step(); step();
        a_ack = 1'b0; a_core_done = 1'b0;
        chk("t4_sticky_halted", {31'b0, a_halted}, 32'h1);
        chk("t4_sticky_err", {30'b0, a_err}, 32'h1);
        chk("t4_sticky_pc", a_pc, 32'h28);
        chk("t4_sticky_retired", a_retired, 32'd12);
        chk("t4_sticky_valid", {31'b0, a_valid}, 32'h0);

        // 5a. No ack ever: timeout after exactly four fetch cycles.
        a_rst = 1'b1;
        #1;
        chk("t5_async_clear_halt", {31'b0, a_halted}, 32'h0);
        chk("t5_async_clear_err", {30'b0, a_err}, 32'h0);
        step();
        a_rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t5_fetch_req", {31'b0, a_req}, 32'h1);
            chk("t5_fetch_not_halted", {31'b0, a_halted}, 32'h0);
            step();
        end
        chk("t5_timeout_halted", {31'b0, a_halted}, 32'h1);
        chk("t5_timeout_err", {30'b0, a_err}, 32'h2);
        chk("t5_timeout_no_req", {31'b0, a_req}, 32'h0);

        // 5b. Ack arriving in the 4th fetch cycle is accepted.
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        step();
        step(); step(); step();
        a_ack = 1'b1; a_rdata = 32'h0BAD_F00D;
        step();
        a_ack = 1'b0;
        chk("t5b_issue_valid", {31'b0, a_valid}, 32'h1);
        chk("t5b_instr", a_instr, 32'h0BAD_F00D);
        chk("t5b_err", {30'b0, a_err}, 32'h0);
        chk("t5b_halted", {31'b0, a_halted}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
